nios2_oci_dct_monitor: RTL and testbench

NIOS2_OCI_DCT_MONITOR -- requirements
Module: nios2_oci_dct_monitor

---
 rtl/nios2_oci_dct_pkg.sv | 23 ++
 rtl/nios2_oci_dct_fifo.sv | 57 +++++
 rtl/nios2_oci_dct_monitor.sv | 144 ++++++++++++++
 tb/tb_nios2_oci_dct_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_dct_pkg.sv
// Shared definitions for the OCI DCT trace monitor.
// Holds default parameter values, the FSM state encoding and the
// default-width capture entry layout {count, buffer}.
package nios2_oci_dct_pkg;

    localparam int DEF_DCT_W  = 30;
    localparam int DEF_SLOT_W = 2;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dct_state_e;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_DCT_W-1:0] buffer;
    } dct_entry_t;

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// Capture FIFO for the DCT monitor: storage plus read/write pointers.
// Pointers carry one extra wrap bit so full and empty are distinguished
// by comparing the MSBs.
// Ports:
//   clk, reset     clock, async active-high reset (pointers only)
//   push, pop      write / read requests
//   wdata          entry to write
//   rdata          head entry (don't-care while empty)
//   full, empty    occupancy flags
module nios2_oci_dct_fifo
    import nios2_oci_dct_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_W + DEF_DCT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // When full, a simultaneous pop frees the very slot the push writes into.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/nios2_oci_dct_monitor.sv
// OCI DCT trace monitor: captures qualified trace words into a FIFO,
// zeroing unused slots, and sequences IDLE/RUN/DRAIN/DONE around the
// end-of-test handshake. Optional statistics counters are built when
// OCI_DCT_MON_STATS_EN is defined.
// Ports:
//   clk, reset                 clock, async active-high reset
//   dct_buffer/count/valid     trace word, valid slot count, strobe
//   test_ending, test_has_ended  drain request / forced stop
//   rd_en, rd_data, rd_valid   reader pop interface ({count, buffer})
//   overflow, count_err        sticky error flags
//   done, state                status / debug state
//   slot_total, drop_total     (OCI_DCT_MON_STATS_EN only) saturating stats
//
// state | meaning
// IDLE  | waiting for first non-empty trace word
// RUN   | capturing trace words
// DRAIN | capture stopped, waiting for reader to empty FIFO
// DONE  | terminal until reset; pops still serviced
module nios2_oci_dct_monitor
    import nios2_oci_dct_pkg::*;
#(
    parameter int DCT_W  = DEF_DCT_W,
    parameter int SLOT_W = DEF_SLOT_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DCT_W-1:0]       dct_buffer,
    input  logic [CNT_W-1:0]       dct_count,
    input  logic                   dct_valid,
    input  logic                   test_ending,
    input  logic                   test_has_ended,
    input  logic                   rd_en,
    output logic [DCT_W+CNT_W-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   overflow,
    output logic                   count_err,
`ifdef OCI_DCT_MON_STATS_EN
    output logic [31:0]            slot_total,
    output logic [15:0]            drop_total,
`endif
    output logic                   done,
    output logic [1:0]             state
);

    localparam int SLOTS = DCT_W / SLOT_W;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]       state_nxt;
    logic             capture_on;
    logic             cnt_good;
    logic             cnt_bad;
    logic             push_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop_ovf;
    logic [DCT_W-1:0] masked_buf;

    // IDLE with test_ending goes straight to DONE, so no capture that cycle.
    assign capture_on = !test_has_ended &&
                        (((state == IDLE) && !test_ending) || (state == RUN));
    assign cnt_good   = (dct_count != '0) && (dct_count <= CNT_W'(SLOTS));
    assign cnt_bad    = (dct_count >  CNT_W'(SLOTS));
    assign push_req   = capture_on && dct_valid && cnt_good;
    assign drop_ovf   = push_req && fifo_full && !rd_en;

    always_comb begin
        masked_buf = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (CNT_W'(i) < dct_count)
                masked_buf[i*SLOT_W +: SLOT_W] = dct_buffer[i*SLOT_W +: SLOT_W];
        end
    end

    nios2_oci_dct_fifo #(
        .WIDTH (DCT_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (rd_en),
        .wdata ({dct_count, masked_buf}),
        .rdata (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_valid = !fifo_empty;
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        if (test_has_ended) begin
            state_nxt = DONE;
        end else begin
            case (state)
                IDLE:    if (test_ending)   state_nxt = DONE;
                         else if (push_req) state_nxt = RUN;
                RUN:     if (test_ending)   state_nxt = DRAIN;
                DRAIN:   if (fifo_empty)    state_nxt = DONE;
                default: state_nxt = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            overflow  <= 1'b0;
            count_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (drop_ovf)                           overflow  <= 1'b1;
            if (capture_on && dct_valid && cnt_bad) count_err <= 1'b1;
        end
    end

`ifdef OCI_DCT_MON_STATS_EN
    logic [32:0] slot_sum;
    logic        drop_evt;

    assign slot_sum = {1'b0, slot_total} + 33'(dct_count);
    assign drop_evt = drop_ovf || (capture_on && dct_valid && cnt_bad);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_total <= '0;
            drop_total <= '0;
        end else begin
            if (push_req && !drop_ovf)
                slot_total <= slot_sum[32] ? '1 : slot_sum[31:0];
            if (drop_evt && (drop_total != '1))
                drop_total <= drop_total + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nios2_oci_dct_monitor.sv
module tb_nios2_oci_dct_monitor;

    localparam int DCT_W  = 30;
    localparam int SLOT_W = 2;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int SLOTS  = DCT_W / SLOT_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [DCT_W-1:0]       dct_buffer;
    logic [CNT_W-1:0]       dct_count;
    logic                   dct_valid;
    logic                   test_ending;
    logic                   test_has_ended;
    logic                   rd_en;
    logic [DCT_W+CNT_W-1:0] rd_data;
    logic                   rd_valid;
    logic                   overflow;
    logic                   count_err;
    logic                   done;
    logic [1:0]             state;
`ifdef OCI_DCT_MON_STATS_EN
    logic [31:0]            slot_total;
    logic [15:0]            drop_total;
`endif

    nios2_oci_dct_monitor #(
        .DCT_W (DCT_W), .SLOT_W (SLOT_W), .CNT_W (CNT_W), .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .overflow       (overflow),
        .count_err      (count_err),
`ifdef OCI_DCT_MON_STATS_EN
        .slot_total     (slot_total),
        .drop_total     (drop_total),
`endif
        .done           (done),
        .state          (state)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: a queue of entries plus a state number 0..3.
    logic [DCT_W+CNT_W-1:0] m_q[$];
    int                     m_st;
    bit                     m_ovf;
    bit                     m_cerr;
    longint                 m_slots;
    longint                 m_drops;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DCT_W-1:0] keep_slots(input logic [DCT_W-1:0] b, input int cnt);
        logic [63:0] m;
        m = (64'd1 << (SLOT_W * cnt)) - 64'd1;
        return b & m[DCT_W-1:0];
    endfunction

    task automatic compare_all();
        check("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check("rd_data", 64'(rd_data), 64'(m_q[0]));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("count_err", 64'(count_err), 64'(m_cerr));
        check("done", 64'(done), 64'(m_st == 3));
        check("state", 64'(state), 64'(m_st));
`ifdef OCI_DCT_MON_STATS_EN
        check("slot_total", 64'(slot_total), 64'(m_slots > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_slots));
        check("drop_total", 64'(drop_total), 64'(m_drops > 65535 ? 65535 : m_drops));
`endif
    endtask

    task automatic model_clock(input bit dv, input int cnt, input logic [DCT_W-1:0] bf,
                               input bit re, input bit te, input bit th);
        bit was_empty, capture, good, bad, popped, accept;
        was_empty = (m_q.size() == 0);
        capture   = !th && ((m_st == 0 && !te) || m_st == 1);
        good      = dv && cnt >= 1 && cnt <= SLOTS;
        bad       = dv && cnt > SLOTS;
        popped    = re && !was_empty;
        accept    = 0;
        if (capture && good) begin
            if (m_q.size() < DEPTH || popped) accept = 1;
            else begin
                m_ovf = 1;
                m_drops++;
            end
        end
        if (capture && bad) begin
            m_cerr = 1;
            m_drops++;
        end
        if (popped) void'(m_q.pop_front());
        if (accept) begin
            m_q.push_back({CNT_W'(cnt), keep_slots(bf, cnt)});
            m_slots += cnt;
        end
        if (th) m_st = 3;
        else if (m_st == 0) begin
            if (te) m_st = 3;
            else if (accept) m_st = 1;
        end else if (m_st == 1) begin
            if (te) m_st = 2;
        end else if (m_st == 2) begin
            if (was_empty) m_st = 3;
        end
    endtask

    task automatic step(input bit dv, input int cnt, input logic [DCT_W-1:0] bf,
                        input bit re, input bit te, input bit th);
        dct_valid      = dv;
        dct_count      = CNT_W'(cnt);
        dct_buffer     = bf;
        rd_en          = re;
        test_ending    = te;
        test_has_ended = th;
        @(posedge clk);
        model_clock(dv, cnt, bf, re, te, th);
        #1;
        compare_all();
    endtask

    task automatic idle_step();
        step(0, 0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        dct_valid      = 1'b0;
        dct_count      = '0;
        dct_buffer     = '0;
        rd_en          = 1'b0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        #1;
        m_q.delete();
        m_st    = 0;
        m_ovf   = 0;
        m_cerr  = 0;
        m_slots = 0;
        m_drops = 0;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [DCT_W-1:0] rnd_buf();
        return DCT_W'({$urandom, $urandom});
    endfunction

    initial begin
        // Single push, slot masking and IDLE->RUN.
        do_reset();
        step(1, 3, 30'h3FFF_FFFF, 0, 0, 0);
        check("first_entry", 64'(rd_data), 64'({4'd3, 30'h0000_003F}));
        check("first_state", 64'(state), 64'd1);

        // Seventeen pushes into a 16-deep FIFO, then drain in order.
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 1 + (i % SLOTS), rnd_buf(), 0, 0, 0);
        check("ovf_after_17", 64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) step(0, 0, '0, 1, 0, 0);
        check("empty_after_16_pops", 64'(rd_valid), 64'd0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 2, rnd_buf(), 0, 0, 0);
        step(1, 7, 30'h1234_5678, 1, 0, 0);
        check("no_ovf_push_pop", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) step(0, 0, '0, 1, 0, 0);

        // Count 15 accepted, count 0 ignored.
        do_reset();
        step(1, 15, rnd_buf(), 0, 0, 0);
        step(1, 0, rnd_buf(), 0, 0, 0);
        step(1, 15, rnd_buf(), 1, 0, 0);
        idle_step();

        // Drain sequence then DONE, later traffic ignored.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 5, rnd_buf(), 0, 0, 0);
        step(0, 0, '0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 4, rnd_buf(), 1, 1, 0);
        step(0, 0, '0, 0, 1, 0);
        check("done_after_drain", 64'(done), 64'd1);
        for (int i = 0; i < 3; i++) step(1, 6, rnd_buf(), 0, 0, 0);

        // Forced stop from RUN, then reset during DRAIN.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 9, rnd_buf(), 0, 0, 0);
        step(1, 9, rnd_buf(), 0, 1, 1);
        check("forced_done", 64'(done), 64'd1);
        do_reset();
        for (int i = 0; i < 2; i++) step(1, 3, rnd_buf(), 0, 0, 0);
        step(0, 0, '0, 0, 1, 0);
        do_reset();
        check("reset_mid_drain", 64'(rd_valid), 64'd0);

        // Randomized traffic with occasional end-of-test events and resets.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                bit te, th;
                te = ($urandom_range(0, 149) == 0);
                th = ($urandom_range(0, 399) == 0);
                step(($urandom_range(0, 9) < 6), $urandom_range(0, 15), rnd_buf(),
                     ($urandom_range(0, 9) < (r % 2 == 0 ? 4 : 7)), te, th);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
